// File: rtl/spi_stepper_pkg.sv
// Shared types, packet field layout and the half-step coil table
// for the SPI-commanded stepper controller.
package spi_stepper_pkg;

  localparam int CMD_PER_W = 16;
  localparam int CMD_PKT_W = 8 + CMD_PER_W;
  localparam int CH_W      = 6;

  localparam int DIR_POS  = CMD_PKT_W - 1;
  localparam int HALF_POS = CMD_PKT_W - 2;
  localparam int CH_MSB   = CMD_PKT_W - 3;
  localparam int CH_LSB   = CMD_PER_W;
  localparam int PER_MSB  = CMD_PER_W - 1;

  typedef struct packed {
    logic                 dir;
    logic                 half;
    logic [CH_W-1:0]      ch;
    logic [CMD_PER_W-1:0] period;
  } step_cmd_t;

  typedef enum logic [1:0] {
    MODE_RELEASE,
    MODE_HOLD,
    MODE_RUN
  } ch_mode_t;

  // {A,B,C,D} per phase index, index 0 in the low nibble
  localparam logic [31:0] HALF_TBL = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
    return HALF_TBL[{idx, 2'b00} +: 4];
  endfunction

  function automatic ch_mode_t ch_mode(input logic dir, input logic per_zero);
    if (!per_zero) return MODE_RUN;
    return dir ? MODE_RELEASE : MODE_HOLD;
  endfunction

  // Full-step from an odd index moves one to realign on an even index.
  function automatic logic [2:0] next_phase(input logic [2:0] idx,
                                            input logic       dir,
                                            input logic       half);
    logic [2:0] stride;
    stride = (half || idx[0]) ? 3'd1 : 3'd2;
    return dir ? idx - stride : idx + stride;
  endfunction

endpackage

// File: rtl/spi_stepper_ctrl_rx.sv
// SPI command receiver: pin synchronizers, shift register, bit counter
// and frame validation, producing one decoded command per good frame.
module spi_cmd_rx
  import spi_stepper_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int PKT_W = CMD_PKT_W
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      cs,
  input  logic      sck,
  input  logic      sdi,
  output step_cmd_t cmd,
  output logic      cmd_valid,
  output logic      cmd_err
);

  localparam int CNT_W = $clog2(PKT_W + 2);
  localparam int CHW1  = CH_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(PKT_W + 1);
  localparam logic [CHW1-1:0]  NCH_LIM  = CHW1'(NCH);

  logic [1:0]       cs_ff, sck_ff, sdi_ff;
  logic             cs_d, sck_d;
  logic             cs_rise, cs_fall, sck_rise;
  logic [PKT_W-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             ch_ok;

  assign cs_rise  = cs_ff[1] & ~cs_d;
  assign cs_fall  = ~cs_ff[1] & cs_d;
  assign sck_rise = sck_ff[1] & ~sck_d;
  assign ch_ok    = {1'b0, shreg[CH_MSB:CH_LSB]} < NCH_LIM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_ff     <= '0;
      sck_ff    <= '0;
      sdi_ff    <= '0;
      cs_d      <= 1'b0;
      sck_d     <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cs_ff     <= {cs_ff[0], cs};
      sck_ff    <= {sck_ff[0], sck};
      sdi_ff    <= {sdi_ff[0], sdi};
      cs_d      <= cs_ff[1];
      sck_d     <= sck_ff[1];
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;

      if (cs_rise) begin
        bit_cnt <= '0;
      end else if (sck_rise && cs_ff[1]) begin
        shreg <= {shreg[PKT_W-2:0], sdi_ff[1]};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
      end

      // sdi and sck share the same sync depth, so sdi_ff[1] is aligned to sck_rise
      if (cs_fall) begin
        if (bit_cnt == CNT_FULL && ch_ok) begin
          cmd_valid  <= 1'b1;
          cmd.dir    <= shreg[DIR_POS];
          cmd.half   <= shreg[HALF_POS];
          cmd.ch     <= shreg[CH_MSB:CH_LSB];
          cmd.period <= shreg[PER_MSB:0];
        end else begin
          cmd_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_stepper_ctrl.sv
// Multi-channel stepper controller: SPI command receiver feeding NCH
// independent step generators that drive 4-coil outputs.
module spi_stepper_ctrl
  import spi_stepper_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int PER_W = CMD_PER_W,
  parameter int PKT_W = 8 + PER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sck,
  input  logic             sdi,
  output logic [4*NCH-1:0] coil,
  output logic             pkt_valid,
  output logic             frame_err
);

  step_cmd_t cmd;
  logic      cmd_valid;
  logic      cmd_err;

  spi_cmd_rx #(
    .NCH   (NCH),
    .PKT_W (PKT_W)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .sck       (sck),
    .sdi       (sdi),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_err   (cmd_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      pkt_valid <= cmd_valid;
      frame_err <= cmd_err;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic             dir_q, half_q, en_q;
    logic [PER_W-1:0] per_q, cnt_q;
    logic [2:0]       phase_q;
    logic             hit, wrap;
    ch_mode_t         mode;

    assign hit  = cmd_valid && (cmd.ch == CH_W'(k));
    assign mode = ch_mode(dir_q, per_q == '0);
    assign wrap = (cnt_q == per_q - 1'b1);

    // A commit takes priority over a step falling on the same edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dir_q   <= 1'b0;
        half_q  <= 1'b0;
        en_q    <= 1'b0;
        per_q   <= '0;
        cnt_q   <= '0;
        phase_q <= '0;
      end else if (hit) begin
        dir_q  <= cmd.dir;
        half_q <= cmd.half;
        per_q  <= PER_W'(cmd.period);
        cnt_q  <= '0;
        en_q   <= (cmd.period != '0) || !cmd.dir;
      end else if (mode == MODE_RUN) begin
        if (wrap) begin
          cnt_q   <= '0;
          phase_q <= next_phase(phase_q, dir_q, half_q);
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign coil[4*k +: 4] = en_q ? coil_pattern(phase_q) : 4'b0000;
  end

endmodule

// File: tb/tb_spi_stepper_ctrl.sv
// Self-checking bench for spi_stepper_ctrl: directed scenarios plus random
// packets, all checked against a closed-form per-channel phase model.
module tb_spi_stepper_ctrl;

  localparam int NCH = 4;

  logic             clk = 1'b0;
  logic             reset, cs, sck, sdi;
  logic [4*NCH-1:0] coil;
  logic             pkt_valid, frame_err;

  always #5 clk = ~clk;

  spi_stepper_ctrl #(.NCH(NCH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .sck       (sck),
    .sdi       (sdi),
    .coil      (coil),
    .pkt_valid (pkt_valid),
    .frame_err (frame_err)
  );

  int     n_cmp = 0;
  int     n_mis = 0;
  longint cyc = 0;
  longint commit_at = -1;
  logic [23:0] pend;
  bit     pend_ok;

  int     m_per  [NCH];
  int     m_base [NCH];
  bit     m_dir  [NCH];
  bit     m_half [NCH];
  bit     m_en   [NCH];
  longint m_c0   [NCH];

  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_per[k] = 0; m_base[k] = 0; m_dir[k] = 0;
      m_half[k] = 0; m_en[k] = 0; m_c0[k] = 0;
    end
    commit_at = -1;
    pend_ok   = 0;
  endfunction

  // Phase after n whole steps since the last commit, from plain arithmetic.
  function automatic int phase_at(input int k, input longint c);
    int n, b, p;
    if (m_per[k] == 0) return m_base[k];
    n = int'((c - m_c0[k]) / m_per[k]);
    b = m_base[k];
    if (m_half[k])     p = m_dir[k] ? b - n : b + n;
    else if (n == 0)   p = b;
    else if (b % 2)    p = m_dir[k] ? b - 1 - 2*(n-1) : b + 1 + 2*(n-1);
    else               p = m_dir[k] ? b - 2*n : b + 2*n;
    return p & 7;
  endfunction

  function automatic logic [4*NCH-1:0] model_coil(input longint c);
    logic [4*NCH-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++)
      if (m_en[k]) v[4*k +: 4] = tbl[phase_at(k, c)];
    return v;
  endfunction

  function automatic void apply_commit();
    int k;
    if (!pend_ok) return;
    k = int'(pend[21:16]);
    m_base[k] = phase_at(k, cyc - 1);
    m_dir[k]  = pend[23];
    m_half[k] = pend[22];
    m_per[k]  = int'(pend[15:0]);
    m_en[k]   = !(m_per[k] == 0 && m_dir[k]);
    m_c0[k]   = cyc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == commit_at) apply_commit();
    check_val("pkt_valid", pkt_valid, (cyc == commit_at) && pend_ok);
    check_val("frame_err", frame_err, (cyc == commit_at) && !pend_ok);
    check_val("coil", coil, model_coil(cyc));
  endtask

  task automatic send_bits(input logic [31:0] word, input int nbits);
    cs = 1'b1;
    repeat (4) tick();
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = word[i];
      repeat (2) tick();
      sck = 1'b1;
      repeat (4) tick();
      sck = 1'b0;
      repeat (3) tick();
    end
    repeat (3) tick();
  endtask

  // align >= 0 delays the cs fall so channel 0's counter reads align just before commit.
  task automatic send_frame(input logic [31:0] word, input int nbits, input int align);
    send_bits(word, nbits);
    if (align >= 0 && m_per[0] != 0)
      for (int g = 0; g < 40 && ((cyc + 3 - m_c0[0]) % m_per[0]) != align; g++) tick();
    cs        = 1'b0;
    pend      = word[23:0];
    pend_ok   = (nbits == 24) && (int'(word[21:16]) < NCH);
    commit_at = cyc + 4;
    repeat (4) tick();
  endtask

  initial begin
    longint     t0;
    logic [3:0] pat;
    logic [31:0] w;
    int         nb;

    reset = 1'b1; cs = 1'b0; sck = 1'b0; sdi = 1'b0;
    model_reset();
    repeat (3) tick();
    check_val("rst_coil", coil, 0);
    reset = 1'b0;
    repeat (5) tick();

    // full-step forward on channel 1, period 5375
    send_frame(32'h0114FF, 24, -1);
    t0 = cyc;
    check_val("ch1_start", coil[7:4], 4'b1000);
    check_val("ch1_others", {coil[15:8], coil[3:0]}, 0);
    while (cyc < t0 + 5374) tick();
    check_val("ch1_pre_step", coil[7:4], 4'b1000);
    tick();
    check_val("ch1_step1", coil[7:4], 4'b0100);
    while (cyc < t0 + 10750) tick();
    check_val("ch1_step2", coil[7:4], 4'b0010);
    check_val("ch1_others2", {coil[15:8], coil[3:0]}, 0);

    // reverse half-step on channel 2, then hold, then release
    send_frame(32'hC20004, 24, -1);
    check_val("ch2_rev0", coil[11:8], 4'b1000);
    repeat (4) tick();
    check_val("ch2_rev1", coil[11:8], 4'b1001);
    repeat (4) tick();
    check_val("ch2_rev2", coil[11:8], 4'b0001);
    repeat (4) tick();
    check_val("ch2_rev3", coil[11:8], 4'b0011);
    send_frame(32'h020000, 24, -1);
    pat = tbl[phase_at(2, cyc)];
    repeat (100) tick();
    check_val("ch2_hold", coil[11:8], pat);
    send_frame(32'h820000, 24, -1);
    check_val("ch2_release", coil[11:8], 4'b0000);

    // short, overrun and out-of-range channel frames
    send_frame(32'h0114FF, 23, -1);
    send_frame(32'h10114FF, 25, -1);
    send_frame(32'h050010, 24, -1);

    // re-commit channel 0 mid-count
    send_frame(32'h00000A, 24, -1);
    repeat (15) tick();
    send_frame(32'h000003, 24, 7);
    t0 = cyc;
    pat = tbl[phase_at(0, t0)];
    repeat (2) tick();
    check_val("recommit_hold", coil[3:0], pat);
    tick();
    check_val("recommit_step", coil[3:0], tbl[phase_at(0, t0 + 3)]);
    check_val("recommit_moved", coil[3:0] != pat, 1);

    // random packets
    for (int r = 0; r < 16; r++) begin
      w = '0;
      w[23]    = 1'($urandom_range(0, 1));
      w[22]    = 1'($urandom_range(0, 1));
      w[21:16] = 6'($urandom_range(0, 5));
      w[15:0]  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      case ($urandom_range(0, 9))
        0:       nb = 23;
        1:       nb = 25;
        default: nb = 24;
      endcase
      if (nb == 25) w[24] = 1'($urandom_range(0, 1));
      send_frame(w, nb, -1);
      repeat ($urandom_range(3, 30)) tick();
    end

    // reset in the middle of a frame, then a clean channel 0 command
    send_bits(32'h0014FF >> 12, 12);
    reset = 1'b1; cs = 1'b0; sck = 1'b0; sdi = 1'b0;
    model_reset();
    repeat (3) tick();
    check_val("midrst_coil", coil, 0);
    reset = 1'b0;
    repeat (5) tick();
    send_frame(32'h0014FF, 24, -1);
    check_val("ch0_after_reset", coil[3:0], 4'b1000);
    check_val("rst_others", coil[15:4], 0);
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
